cpu_run_ctrl: RTL and testbench

Synthesizable run controller that sits between the board/top level and the `cpu` core, doing in hardware what the simulation bench does around the CPU. It sequences the CPU's active-low reset and starts a run. It counts execution cycles, detects the CPU's `hlt` output and latches the final `pc`. An optional watchdog aborts runaway programs.

---
 rtl/cpu_run_ctrl_if.sv | 25 ++
 rtl/cpu_run_ctrl.sv | 115 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Bus between the run controller and its surroundings: run control inputs,
// CPU halt/pc observation, and the controller's status outputs.
interface cpu_run_ctrl_if #(
   parameter int unsigned PC_W = 16
);
   logic            start;
   logic            hlt;
   logic [PC_W-1:0] pc;
   logic            cpu_rst_n;
   logic            running;
   logic            done;
   logic            timeout;
   logic [15:0]     cycle_cnt;
   logic [PC_W-1:0] halt_pc;

   modport master (
      output start, hlt, pc,
      input  cpu_rst_n, running, done, timeout, cycle_cnt, halt_pc
   );

   modport slave (
      input  start, hlt, pc,
      output cpu_rst_n, running, done, timeout, cycle_cnt, halt_pc
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the cpu core: sequences its reset, counts RUN cycles, latches pc on halt.
// Optional watchdog (TMO state) is compiled in with `define CPU_RUN_WDOG_EN.
module cpu_run_ctrl #(
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 1000,
   parameter int unsigned PC_W       = 16
) (
   input  logic          clk,
   input  logic          rst,
   cpu_run_ctrl_if.slave bus
);

   if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
      $error("RST_CYCLES out of range 1..255");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("TIMEOUT out of range 1..65535");
   end

   typedef enum logic [2:0] {
      StIdle,
      StReset,
      StRun,
      StHalt
`ifdef CPU_RUN_WDOG_EN
      , StTmo
`endif
   } state_e;

   localparam logic [7:0] RstLoad = 8'(RST_CYCLES - 1);

   state_e          state_q, state_d;
   logic [7:0]      rst_cnt_q, rst_cnt_d;
   logic [15:0]     cycle_cnt_q, cycle_cnt_d;
   logic [PC_W-1:0] halt_pc_q, halt_pc_d;
   logic [15:0]     cycle_inc;

   // Saturating increment; with the watchdog present it never reaches the ceiling.
   assign cycle_inc = (cycle_cnt_q == 16'hFFFF) ? cycle_cnt_q : cycle_cnt_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      halt_pc_d   = halt_pc_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d   = StReset;
               rst_cnt_d = RstLoad;
            end
         end
         StReset: begin
            if (bus.start) begin
               rst_cnt_d = RstLoad;
            end else if (rst_cnt_q == 8'd0) begin
               state_d     = StRun;
               cycle_cnt_d = 16'd0;
            end else begin
               rst_cnt_d = rst_cnt_q - 8'd1;
            end
         end
         StRun: begin
            cycle_cnt_d = cycle_inc;
            if (bus.hlt) begin
               state_d   = StHalt;
               halt_pc_d = bus.pc;
            end
`ifdef CPU_RUN_WDOG_EN
            else if ({1'b0, cycle_cnt_q} + 17'd1 == 17'(TIMEOUT)) begin
               state_d = StTmo;
            end
`endif
         end
`ifdef CPU_RUN_WDOG_EN
         StTmo,
`endif
         StHalt: begin
            if (bus.start) begin
               state_d   = StReset;
               rst_cnt_d = RstLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rst_cnt_q   <= 8'd0;
         cycle_cnt_q <= 16'd0;
         halt_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         halt_pc_q   <= halt_pc_d;
      end
   end

   // Status is decoded from the state flop only, so no input reaches an output combinationally.
   assign bus.cpu_rst_n = (state_q == StRun) || (state_q == StHalt);
   assign bus.running   = (state_q == StRun);
`ifdef CPU_RUN_WDOG_EN
   assign bus.done      = (state_q == StHalt) || (state_q == StTmo);
   assign bus.timeout   = (state_q == StTmo);
`else
   assign bus.done      = (state_q == StHalt);
   assign bus.timeout   = 1'b0;
`endif
   assign bus.cycle_cnt = cycle_cnt_q;
   assign bus.halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with default parameters (RST_CYCLES=2, TIMEOUT=1000).
// Watchdog checks run when CPU_RUN_WDOG_EN is defined, saturation checks otherwise.
module tb_cpu_run_ctrl;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   cpu_run_ctrl_if #(.PC_W(16)) bus ();

   cpu_run_ctrl #(
      .RST_CYCLES(2),
      .TIMEOUT   (1000),
      .PC_W      (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One active edge, then park on the falling edge where outputs are sampled.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.hlt   = 1'b0;
      bus.pc    = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
      checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", bus.running); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
      checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cycle_cnt got=%h exp=0", bus.cycle_cnt); end
      checks++; if (bus.halt_pc !== 16'd0) begin errors++; $display("FAIL reset_halt_pc got=%h exp=0", bus.halt_pc); end
      bus.hlt = 1'b1;
      repeat (5) step();
      bus.hlt = 1'b0;
      checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL idle_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL idle_hlt_ignored got=%b exp=0", bus.done); end
   endtask

   // Pulse start and follow the two reset edges into RUN.
   task automatic test_start(input string tag);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL %s_rst_e1 got=%b exp=0", tag, bus.cpu_rst_n); end
      step();
      checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL %s_rst_e2 got=%b exp=0", tag, bus.cpu_rst_n); end
      step();
      checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL %s_rst_rise got=%b exp=1", tag, bus.cpu_rst_n); end
      checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL %s_running got=%b exp=1", tag, bus.running); end
      checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL %s_cnt_clear got=%h exp=0", tag, bus.cycle_cnt); end
   endtask

   task automatic test_halt();
      repeat (36) step();
      checks++; if (bus.cycle_cnt !== 16'd36) begin errors++; $display("FAIL halt_pre_cnt got=%0d exp=36", bus.cycle_cnt); end
      bus.hlt = 1'b1;
      bus.pc  = 16'h00A4;
      step();
      bus.hlt = 1'b0;
      bus.pc  = 16'h5555;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL halt_done got=%b exp=1", bus.done); end
      checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL halt_running got=%b exp=0", bus.running); end
      checks++; if (bus.cycle_cnt !== 16'd37) begin errors++; $display("FAIL halt_cnt got=%0d exp=37", bus.cycle_cnt); end
      checks++; if (bus.halt_pc !== 16'h00A4) begin errors++; $display("FAIL halt_pc got=%h exp=00a4", bus.halt_pc); end
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL halt_timeout got=%b exp=0", bus.timeout); end
      checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL halt_cpu_rst_n got=%b exp=1", bus.cpu_rst_n); end
      bus.hlt = 1'b1;
      bus.pc  = 16'hFFFF;
      repeat (2) step();
      bus.hlt = 1'b0;
      checks++; if (bus.halt_pc !== 16'h00A4) begin errors++; $display("FAIL halt_pc_hold got=%h exp=00a4", bus.halt_pc); end
      checks++; if (bus.cycle_cnt !== 16'd37) begin errors++; $display("FAIL halt_cnt_hold got=%0d exp=37", bus.cycle_cnt); end
   endtask

   task automatic test_restart_and_async_rst();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++; if (bus.cycle_cnt !== 16'd37) begin errors++; $display("FAIL restart_cnt_kept got=%0d exp=37", bus.cycle_cnt); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL restart_done got=%b exp=0", bus.done); end
      repeat (2) step();
      checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL restart_cnt_clear got=%0d exp=0", bus.cycle_cnt); end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (49) step();
      checks++; if (bus.cycle_cnt !== 16'd50) begin errors++; $display("FAIL run_start_ignored got=%0d exp=50", bus.cycle_cnt); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL async_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
      checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL async_running got=%b exp=0", bus.running); end
      checks++; if (bus.cycle_cnt !== 16'd0) begin errors++; $display("FAIL async_cnt got=%0d exp=0", bus.cycle_cnt); end
      checks++; if (bus.halt_pc !== 16'd0) begin errors++; $display("FAIL async_halt_pc got=%h exp=0", bus.halt_pc); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reload();
      bus.start = 1'b1;
      step();
      step();
      bus.start = 1'b0;
      step();
      checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reload_low1 got=%b exp=0", bus.cpu_rst_n); end
      step();
      checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL reload_rise got=%b exp=1", bus.cpu_rst_n); end
   endtask

`ifdef CPU_RUN_WDOG_EN
   task automatic test_watchdog();
      repeat (999) step();
      checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL wdog_pre_running got=%b exp=1", bus.running); end
      step();
      checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL wdog_timeout got=%b exp=1", bus.timeout); end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wdog_done got=%b exp=1", bus.done); end
      checks++; if (bus.cycle_cnt !== 16'd1000) begin errors++; $display("FAIL wdog_cnt got=%0d exp=1000", bus.cycle_cnt); end
      checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL wdog_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
      test_start("wdog_restart");
      repeat (999) step();
      bus.hlt = 1'b1;
      bus.pc  = 16'h1234;
      step();
      bus.hlt = 1'b0;
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL tie_timeout got=%b exp=0", bus.timeout); end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL tie_done got=%b exp=1", bus.done); end
      checks++; if (bus.cycle_cnt !== 16'd1000) begin errors++; $display("FAIL tie_cnt got=%0d exp=1000", bus.cycle_cnt); end
      checks++; if (bus.halt_pc !== 16'h1234) begin errors++; $display("FAIL tie_halt_pc got=%h exp=1234", bus.halt_pc); end
   endtask
`else
   task automatic test_saturate();
      repeat (1000) step();
      checks++; if (bus.cycle_cnt !== 16'd1000) begin errors++; $display("FAIL nowdog_cnt1000 got=%0d exp=1000", bus.cycle_cnt); end
      checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL nowdog_running1000 got=%b exp=1", bus.running); end
      repeat (69000) step();
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL sat_timeout got=%b exp=0", bus.timeout); end
      checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL sat_running got=%b exp=1", bus.running); end
      checks++; if (bus.cycle_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got=%h exp=ffff", bus.cycle_cnt); end
      bus.hlt = 1'b1;
      bus.pc  = 16'hBEEF;
      step();
      bus.hlt = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL sat_halt_done got=%b exp=1", bus.done); end
      checks++; if (bus.cycle_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_halt_cnt got=%h exp=ffff", bus.cycle_cnt); end
      checks++; if (bus.halt_pc !== 16'hBEEF) begin errors++; $display("FAIL sat_halt_pc got=%h exp=beef", bus.halt_pc); end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_start("start");
      test_halt();
      test_restart_and_async_rst();
      test_reload();
`ifdef CPU_RUN_WDOG_EN
      test_watchdog();
`else
      test_saturate();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
